// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch engine with a small in-order instruction queue
//
// Purpose: issues single-outstanding word reads to instruction memory, queues the
// returned words with their addresses, and presents the oldest entry to decode.
// A redirect flushes the queue and restarts fetch at the new (word-aligned) address.
//
// Parameters:
//   ENTRY       fetch address loaded on reset
//   DEPTH       queue entries, power of two in 2..8
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   redirect    flush request; redirect_pc is the new fetch address
//   imem_req    read request, held until imem_ack
//   imem_addr   address of the outstanding request
//   imem_ack    response strobe, imem_data valid in the same cycle
//   out_valid   head entry available
//   out_ready   decode accepts the head entry
//   out_ins     head instruction word
//   out_pc      head instruction address
//   out_pcp4    out_pc + 4
//   count       occupied entries

module fetch_queue #(
    parameter logic [31:0] ENTRY = 32'h80,
    parameter int          DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcp4,
    output logic [3:0]  count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            r_state;
    logic [31:0]       r_fetch_pc;
    logic [31:0]       r_addr;
    logic              r_req;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [3:0]        r_count;
    logic [31:0]       r_ins [DEPTH];
    logic [31:0]       r_pc  [DEPTH];

    logic              w_full;
    logic              w_enq;
    logic              w_deq;
    logic [31:0]       w_redirect_pc;

    // Masking instead of slicing keeps every redirect_pc bit in use.
    assign w_redirect_pc = redirect_pc & ~32'h3;
    assign w_full        = (r_count == 4'(DEPTH));

    // Redirect wins over both queue operations so nothing older survives a flush.
    assign w_enq = (r_state == S_WAIT) && imem_ack && !redirect;
    assign w_deq = (r_count != 4'd0) && out_ready && !redirect;

    // Fetch FSM: one request in flight; DROP waits out a request made stale by a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= ENTRY;
            r_addr     <= ENTRY;
            r_req      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                    end else if (!w_full) begin
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                        if (redirect) begin
                            r_fetch_pc <= w_redirect_pc;
                        end else begin
                            r_fetch_pc <= r_fetch_pc + 32'd4;
                        end
                    end else if (redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                        r_state    <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                    end
                    // The stale request still has to complete before a new one may issue.
                    if (imem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Instruction queue: DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ins[i] <= 32'd0;
                r_pc[i]  <= 32'd0;
            end
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_enq) begin
                r_ins[r_wr_ptr] <= imem_data;
                r_pc[r_wr_ptr]  <= r_fetch_pc;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign out_valid = (r_count != 4'd0);
    assign out_ins   = r_ins[r_rd_ptr];
    assign out_pc    = r_pc[r_rd_ptr];
    assign out_pcp4  = out_pc + 32'd4;
    assign count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic [31:0] out_pcp4;
    logic [3:0]  count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    fetch_queue #(
        .ENTRY(32'h80),
        .DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ins    (out_ins),
        .out_pc     (out_pc),
        .out_pcp4   (out_pcp4),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h (failures so far %0d)", tag, obs, exp, n_fail);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input string tag, input logic [31:0] a);
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_addr"}, imem_addr, a);
    endtask

    task automatic give_ack(input logic [31:0] a);
        imem_ack  = 1'b1;
        imem_data = dfn(a);
        step();
        imem_ack  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_data = 32'd0; out_ready = 1'b1;
        step(); step();
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ins",   out_ins, 32'd0);
        check("rst_pc",    out_pc, 32'd0);

        // Streaming with decode always ready, ack one cycle after each request
        rst_n = 1'b1;
        step();
        expect_req("s0", 32'h80);
        give_ack(32'h80);
        check("s0_count", 32'(count), 32'd1);
        check("s0_pc",    out_pc, 32'h80);
        check("s0_pcp4",  out_pcp4, 32'h84);
        check("s0_ins",   out_ins, dfn(32'h80));
        check("s0_idle",  32'(imem_req), 32'd0);
        step();
        check("s1_drain", 32'(count), 32'd0);
        expect_req("s1", 32'h84);
        give_ack(32'h84);
        check("s1_pc",  out_pc, 32'h84);
        check("s1_ins", out_ins, dfn(32'h84));
        step();
        expect_req("s2", 32'h88);
        give_ack(32'h88);
        check("s2_pc",   out_pc, 32'h88);
        check("s2_pcp4", out_pcp4, 32'h8C);

        // Fill to DEPTH with decode stalled
        rst_n = 1'b0;
        #1;
        check("r2_count", 32'(count), 32'd0);
        check("r2_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            expect_req($sformatf("fill%0d", i), 32'h80 + 32'(4 * i));
            give_ack(32'h80 + 32'(4 * i));
            check($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
        end
        step();
        check("full_noreq0", 32'(imem_req), 32'd0);
        step();
        check("full_noreq1", 32'(imem_req), 32'd0);
        check("full_count",  32'(count), 32'd4);
        check("full_head",   out_pc, 32'h80);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pulse_count", 32'(count), 32'd3);
        check("pulse_head",  out_pc, 32'h84);
        check("pulse_noreq", 32'(imem_req), 32'd0);
        step();
        expect_req("refetch", 32'h90);

        // Redirect while waiting on memory with two entries queued
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("wait_count", 32'(count), 32'd2);
        expect_req("wait_hold", 32'h90);
        redirect = 1'b1; redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        check("rd_count", 32'(count), 32'd0);
        check("rd_valid", 32'(out_valid), 32'd0);
        expect_req("drop0", 32'h90);
        step();
        expect_req("drop1", 32'h90);
        give_ack(32'h90);
        check("drop_count", 32'(count), 32'd0);
        check("drop_idle",  32'(imem_req), 32'd0);
        step();
        expect_req("rd_new", 32'h100);

        // Redirect and ack in the same cycle
        redirect = 1'b1; redirect_pc = 32'h200;
        imem_ack = 1'b1; imem_data = dfn(32'h100);
        step();
        redirect = 1'b0; imem_ack = 1'b0;
        check("ra_count", 32'(count), 32'd0);
        check("ra_idle",  32'(imem_req), 32'd0);
        step();
        expect_req("ra_new", 32'h200);

        // Enqueue into an empty queue must not bypass; then enqueue+dequeue at count 1
        imem_ack = 1'b1; imem_data = dfn(32'h200);
        #1;
        check("no_bypass", 32'(out_valid), 32'd0);
        step();
        imem_ack = 1'b0;
        check("e1_count", 32'(count), 32'd1);
        check("e1_ins",   out_ins, dfn(32'h200));
        step();
        expect_req("e2", 32'h204);
        out_ready = 1'b1;
        give_ack(32'h204);
        out_ready = 1'b0;
        check("ed_count", 32'(count), 32'd1);
        check("ed_ins",   out_ins, dfn(32'h204));
        check("ed_pc",    out_pc, 32'h204);
        step();
        expect_req("e3", 32'h208);

        // Asynchronous reset while a request is outstanding; stray ack ignored
        rst_n = 1'b0;
        #1;
        check("ar_req",   32'(imem_req), 32'd0);
        check("ar_count", 32'(count), 32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        imem_ack = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        imem_ack = 1'b0;
        check("ar_stray", 32'(count), 32'd0);
        expect_req("ar_new", 32'h80);
        step();
        check("ar_hold_count", 32'(count), 32'd0);
        expect_req("ar_hold", 32'h80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter ENTRY, default 32'h80, meaning fetch address loaded on reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..8).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port redirect  input  1  flush request from branch/jump/interrupt logic.
REQ-006 The block SHALL have port redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-007 The block SHALL have port imem_req  output  1  instruction memory read request.
REQ-008 The block SHALL have port imem_addr  output  32  word address of the outstanding request.
REQ-009 The block SHALL have port imem_ack  input  1  memory response strobe; imem_data valid this cycle.
REQ-010 The block SHALL have port imem_data  input  32  fetched instruction word.
REQ-011 The block SHALL have port out_valid  output  1  head entry available to decode.
REQ-012 The block SHALL have port out_ready  input  1  decode accepts head entry this cycle.
REQ-013 The block SHALL have port out_ins  output  32  head instruction.
REQ-014 The block SHALL have port out_pc  output  32  address of head instruction.
REQ-015 The block SHALL have port out_pcp4  output  32  out_pc + 4, modulo 2^32.
REQ-016 The block SHALL have port count  output  4  current number of occupied entries.

Function
REQ-017 The block SHALL implement a fetch FSM with states IDLE, WAIT and DROP, with at most one outstanding memory request.
REQ-018 In IDLE with count < DEPTH and redirect=0, the FSM SHALL assert imem_req with imem_addr=fetch_pc and move to WAIT on the next edge.
REQ-019 In WAIT, imem_req SHALL stay 1 and imem_addr SHALL stay constant until the cycle imem_ack=1.
REQ-020 In WAIT on imem_ack=1 without redirect, the block SHALL enqueue {fetch_pc, imem_data}, set fetch_pc to fetch_pc+4 (wrapping mod 2^32), and return to IDLE.
REQ-021 In IDLE with count == DEPTH, imem_req SHALL be 0 and the FSM SHALL remain in IDLE.
REQ-022 Issue latency SHALL be one cycle, and a back-to-back fetch SHALL restart from IDLE, giving a peak rate of one instruction per two cycles when ack is immediate.
REQ-023 On redirect=1, the block SHALL set count to 0 on the next edge, reset both FIFO pointers, and load fetch_pc with {redirect_pc[31:2], 2'b00}.
REQ-024 Redirect SHALL take priority over a same-cycle enqueue and a same-cycle dequeue, so no entry from before the redirect survives.
REQ-025 Redirect in WAIT without ack SHALL move the FSM to DROP, in which imem_req stays 1 with the original address until ack, the data is discarded, and the FSM then moves to IDLE.
REQ-026 Redirect in WAIT with ack SHALL discard the data and move the FSM to IDLE.
REQ-027 Redirect in DROP SHALL update fetch_pc only and keep the FSM in DROP.
REQ-028 out_valid SHALL equal (count != 0), and out_ins, out_pc and out_pcp4 SHALL be driven combinationally from the head entry.
REQ-029 A dequeue SHALL occur when out_valid and out_ready are both 1; it SHALL advance the read pointer (wrapping at DEPTH) and decrement count.
REQ-030 A simultaneous enqueue and dequeue SHALL leave count unchanged, and when count == 0 enqueue SHALL NOT bypass to the outputs in the same cycle.
REQ-031 Because of the single outstanding request and the issue check, enqueue SHALL never occur at count == DEPTH, and dequeue at count == 0 SHALL be ignored.

Reset
REQ-032 While rst_n=0, the block SHALL hold fetch_pc=ENTRY, state=IDLE, count=0, pointers=0, imem_req=0, out_valid=0, out_ins=0 and out_pc=0.
REQ-033 Reset asserted mid-request SHALL abandon the request immediately, and a later ack for that request SHALL be ignored while in IDLE.
REQ-034 On the first edge after rst_n rises, the block SHALL issue imem_req with imem_addr=ENTRY.

Verification
REQ-035 Verification SHALL cover reset release with out_ready=1 and ack one cycle after each req -> imem_addr sequence 0x80, 0x84, 0x88, and out_pc follows with out_pcp4=out_pc+4.
REQ-036 Verification SHALL cover out_ready=0 with immediate acks -> count reaches 4, imem_req is 0 and stays 0; a single out_ready pulse then gives count 3 followed by a refetch of 0x90.
REQ-037 Verification SHALL cover a redirect to 0x103 while count=2 and in WAIT -> next cycle count=0, state DROP; the ack data is discarded and the next imem_addr is 0x100.
REQ-038 Verification SHALL cover redirect and ack in the same cycle in WAIT -> no enqueue, and the next request addresses redirect_pc.
REQ-039 Verification SHALL cover a simultaneous enqueue and dequeue at count=1 -> count stays 1 and out_ins becomes the newer word.
REQ-040 Verification SHALL cover rst_n driven low during WAIT -> imem_req=0 and count=0 immediately without a clock; after release imem_addr=0x80.
